// File: rtl/pipeline_pkg.sv
// Shared types and widths for the MEM pipeline stage and its MEM/WB register.
// Latency: not applicable, this package holds declarations only.
// Backpressure: not applicable, this package holds declarations only.
// Contents: FSM state enum, datapath widths, misalignment helper.
package pipeline_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int PC_IDX_W   = 8;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Word accesses only: any memory op with a non-zero byte offset is misaligned.
  function automatic logic is_misaligned(input logic memop, input logic [1:0] addr_lo);
    return memop & (addr_lo != 2'b00);
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack bus between the MEM stage (master) and data memory (slave).
// Latency: variable; ack may arrive in the same cycle as req or any later cycle.
// Backpressure: master holds req, we, addr and wdata stable until ack.
// Signals: dmem_req, dmem_we, dmem_addr, dmem_wdata (master -> slave);
//          dmem_ack, dmem_rdata (slave -> master, rdata valid with ack).
interface mem_access_stage_if;
  import pipeline_pkg::*;

  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );

endinterface

// File: rtl/mem_access_stage_mem_wb.sv
// MEM/WB pipeline register with a bubble input that squashes the control bits.
// Latency: one cycle from input to output.
// Backpressure: none; on bubble the control bits go to 0 and ALU/reg fields hold.
// Ports: clk, reset; bubble; RegWrite, MemtoReg, ALUresult, writeReg, rdata_vld,
//        rdata in; RegWriteOut, MemtoRegOut, ReadDataOut, ALUResultOut, writeRegOut out.
module mem_wb_register
  import pipeline_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bubble,
  input  logic                  RegWrite,
  input  logic                  MemtoReg,
  input  logic [DATA_W-1:0]     ALUresult,
  input  logic [REG_ADDR_W-1:0] writeReg,
  input  logic                  rdata_vld,
  input  logic [DATA_W-1:0]     rdata,
  output logic                  RegWriteOut,
  output logic                  MemtoRegOut,
  output logic [DATA_W-1:0]     ReadDataOut,
  output logic [DATA_W-1:0]     ALUResultOut,
  output logic [REG_ADDR_W-1:0] writeRegOut
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RegWriteOut  <= 1'b0;
      MemtoRegOut  <= 1'b0;
      ReadDataOut  <= '0;
      ALUResultOut <= '0;
      writeRegOut  <= '0;
    end else begin
      // Read data is only meaningful in the cycle the memory acks it.
      ReadDataOut <= rdata_vld ? rdata : '0;
      if (bubble) begin
        RegWriteOut <= 1'b0;
        MemtoRegOut <= 1'b0;
      end else begin
        RegWriteOut  <= RegWrite;
        MemtoRegOut  <= MemtoReg;
        ALUResultOut <= ALUresult;
        writeRegOut  <= writeReg;
      end
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives the data-memory bus, resolves branch redirects, feeds WB.
// Latency: one cycle to WB for a zero-wait access, plus one per ack-delay cycle.
// Backpressure: stall holds upstream while a request waits for ack; released in the
//   ack or timeout cycle. Ports: clk, reset, EX/MEM inputs, dmem bus (master), stall,
//   pc_redirect/redirect_target, mem_fault, bus_error, MEM/WB outputs.
module mem_access_stage
  import pipeline_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWrite,
  input  logic                  MemtoReg,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  input  logic                  inBranchTaken,
  input  logic [PC_IDX_W-1:0]   inBranchTarget,
  input  logic [DATA_W-1:0]     ALUresult,
  input  logic [DATA_W-1:0]     writedata,
  input  logic [REG_ADDR_W-1:0] writeReg,
  mem_access_stage_if.master    dmem,
  output logic                  stall,
  output logic                  pc_redirect,
  output logic [PC_IDX_W-1:0]   redirect_target,
  output logic                  mem_fault,
  output logic                  bus_error,
  output logic                  RegWriteOut,
  output logic                  MemtoRegOut,
  output logic [DATA_W-1:0]     ReadDataOut,
  output logic [DATA_W-1:0]     ALUResultOut,
  output logic [REG_ADDR_W-1:0] writeRegOut
);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             memop;
  logic             misaligned;
  logic             in_wait;
  logic             req;
  logic             timeout_now;
  logic             bubble;

  assign memop      = MemRead | MemWrite;
  assign misaligned = is_misaligned(memop, ALUresult[1:0]);
  assign in_wait    = (state == WAIT);

  // Gated by reset so the request drops the instant reset asserts, even if
  // the held EX/MEM contents still describe a memory op.
  assign req = ~reset & (in_wait | (memop & ~misaligned));

  // Ack in the final wait cycle beats the timeout.
  assign timeout_now = in_wait & ~dmem.dmem_ack &
                       (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

  assign stall = req & ~dmem.dmem_ack & ~timeout_now;

  assign dmem.dmem_req   = req;
  assign dmem.dmem_we    = MemWrite;
  assign dmem.dmem_addr  = ALUresult;
  assign dmem.dmem_wdata = writedata;

  // Branches carry no memop, so a stall only delays the redirect.
  assign pc_redirect     = inBranchTaken & ~stall;
  assign redirect_target = inBranchTarget;

  assign bubble = stall | misaligned | timeout_now;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      bus_error <= 1'b0;
      mem_fault <= 1'b0;
    end else begin
      mem_fault <= misaligned;
      unique case (state)
        IDLE: begin
          if (req && !dmem.dmem_ack) begin
            state    <= WAIT;
            wait_cnt <= '0;
          end
        end
        WAIT: begin
          if (dmem.dmem_ack) begin
            state <= IDLE;
          end else if (timeout_now) begin
            state     <= IDLE;
            bus_error <= 1'b1;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mem_wb_register u_mem_wb (
    .clk          (clk),
    .reset        (reset),
    .bubble       (bubble),
    .RegWrite     (RegWrite),
    .MemtoReg     (MemtoReg),
    .ALUresult    (ALUresult),
    .writeReg     (writeReg),
    .rdata_vld    (dmem.dmem_ack),
    .rdata        (dmem.dmem_rdata),
    .RegWriteOut  (RegWriteOut),
    .MemtoRegOut  (MemtoRegOut),
    .ReadDataOut  (ReadDataOut),
    .ALUResultOut (ALUResultOut),
    .writeRegOut  (writeRegOut)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with MEM_TIMEOUT = 4.
// Latency: checks registered outputs 1 time unit after each rising edge.
// Backpressure: drives dmem_ack directly to create zero-wait, delayed and timed-out accesses.
module tb_mem_access_stage;
  import pipeline_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  RegWrite, MemtoReg, MemWrite, MemRead, inBranchTaken;
  logic [PC_IDX_W-1:0]   inBranchTarget;
  logic [DATA_W-1:0]     ALUresult, writedata;
  logic [REG_ADDR_W-1:0] writeReg;
  logic                  stall, pc_redirect, mem_fault, bus_error;
  logic [PC_IDX_W-1:0]   redirect_target;
  logic                  RegWriteOut, MemtoRegOut;
  logic [DATA_W-1:0]     ReadDataOut, ALUResultOut;
  logic [REG_ADDR_W-1:0] writeRegOut;

  int checks = 0;
  int errors = 0;

  mem_access_stage_if dmem_bus ();

  mem_access_stage #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .RegWrite        (RegWrite),
    .MemtoReg        (MemtoReg),
    .MemWrite        (MemWrite),
    .MemRead         (MemRead),
    .inBranchTaken   (inBranchTaken),
    .inBranchTarget  (inBranchTarget),
    .ALUresult       (ALUresult),
    .writedata       (writedata),
    .writeReg        (writeReg),
    .dmem            (dmem_bus),
    .stall           (stall),
    .pc_redirect     (pc_redirect),
    .redirect_target (redirect_target),
    .mem_fault       (mem_fault),
    .bus_error       (bus_error),
    .RegWriteOut     (RegWriteOut),
    .MemtoRegOut     (MemtoRegOut),
    .ReadDataOut     (ReadDataOut),
    .ALUResultOut    (ALUResultOut),
    .writeRegOut     (writeRegOut)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    RegWrite = 0; MemtoReg = 0; MemWrite = 0; MemRead = 0;
    inBranchTaken = 0; inBranchTarget = '0;
    ALUresult = '0; writedata = '0; writeReg = '0;
    dmem_bus.dmem_ack = 0; dmem_bus.dmem_rdata = '0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle_inputs();
    #2;
    checks++; if (dmem_bus.dmem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", dmem_bus.dmem_req); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", stall); end
    checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL rst_bus_error: got %b want 0", bus_error); end
    checks++; if (mem_fault !== 1'b0) begin errors++; $display("FAIL rst_mem_fault: got %b want 0", mem_fault); end
    checks++; if ({RegWriteOut, MemtoRegOut, ReadDataOut, ALUResultOut, writeRegOut} !== '0) begin
      errors++; $display("FAIL rst_wb: got %b/%b/%h/%h/%h want all 0", RegWriteOut, MemtoRegOut, ReadDataOut, ALUResultOut, writeRegOut);
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_zero_wait_load;
    MemRead = 1; RegWrite = 1; MemtoReg = 1; ALUresult = 32'h10; writeReg = 5'd5;
    dmem_bus.dmem_ack = 1; dmem_bus.dmem_rdata = 32'hDEADBEEF;
    #1;
    checks++; if (dmem_bus.dmem_req !== 1'b1) begin errors++; $display("FAIL zw_req: got %b want 1", dmem_bus.dmem_req); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zw_stall: got %b want 0", stall); end
    checks++; if (dmem_bus.dmem_we !== 1'b0 || dmem_bus.dmem_addr !== 32'h10) begin
      errors++; $display("FAIL zw_bus: got we=%b addr=%h want we=0 addr=00000010", dmem_bus.dmem_we, dmem_bus.dmem_addr);
    end
    tick();
    checks++; if (RegWriteOut !== 1'b1 || MemtoRegOut !== 1'b1) begin errors++; $display("FAIL zw_ctrl: got %b%b want 11", RegWriteOut, MemtoRegOut); end
    checks++; if (ReadDataOut !== 32'hDEADBEEF) begin errors++; $display("FAIL zw_rdata: got %h want deadbeef", ReadDataOut); end
    checks++; if (ALUResultOut !== 32'h10 || writeRegOut !== 5'd5) begin errors++; $display("FAIL zw_fields: got %h/%0d want 10/5", ALUResultOut, writeRegOut); end
    idle_inputs();
  endtask

  task automatic test_store_wait;
    int stall_cycles;
    stall_cycles = 0;
    MemWrite = 1; ALUresult = 32'h20; writedata = 32'h1234;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) dmem_bus.dmem_ack = 1;
      #1;
      if (stall === 1'b1) stall_cycles++;
      checks++; if (dmem_bus.dmem_req !== 1'b1 || dmem_bus.dmem_we !== 1'b1 || dmem_bus.dmem_addr !== 32'h20 || dmem_bus.dmem_wdata !== 32'h1234) begin
        errors++; $display("FAIL st_bus_c%0d: got req=%b we=%b addr=%h wdata=%h want 1 1 20 1234", c, dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_addr, dmem_bus.dmem_wdata);
      end
      tick();
      checks++; if (RegWriteOut !== 1'b0) begin errors++; $display("FAIL st_regwrite_c%0d: got %b want 0", c, RegWriteOut); end
    end
    checks++; if (stall_cycles != 2) begin errors++; $display("FAIL st_stall_cycles: got %0d want 2", stall_cycles); end
    idle_inputs();
    #1;
    checks++; if (dmem_bus.dmem_req !== 1'b0) begin errors++; $display("FAIL st_back_idle: got req=%b want 0", dmem_bus.dmem_req); end
  endtask

  task automatic test_misaligned;
    MemRead = 1; RegWrite = 1; MemtoReg = 1; ALUresult = 32'h13; writeReg = 5'd3;
    #1;
    checks++; if (dmem_bus.dmem_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL mis_req_stall: got %b%b want 00", dmem_bus.dmem_req, stall); end
    tick();
    checks++; if (mem_fault !== 1'b1) begin errors++; $display("FAIL mis_fault: got %b want 1", mem_fault); end
    checks++; if (RegWriteOut !== 1'b0) begin errors++; $display("FAIL mis_regwrite: got %b want 0", RegWriteOut); end
    idle_inputs();
    tick();
    checks++; if (mem_fault !== 1'b0) begin errors++; $display("FAIL mis_pulse_end: got %b want 0", mem_fault); end
  endtask

  task automatic test_back_to_back;
    MemRead = 1; RegWrite = 1; MemtoReg = 1; ALUresult = 32'h100; writeReg = 5'd7;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_stall1: got %b want 1", stall); end
    tick();
    checks++; if (RegWriteOut !== 1'b0) begin errors++; $display("FAIL b2b_bubble: got %b want 0", RegWriteOut); end
    dmem_bus.dmem_ack = 1; dmem_bus.dmem_rdata = 32'hCAFE0001;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_stall_ack: got %b want 0", stall); end
    tick();
    checks++; if (RegWriteOut !== 1'b1 || ReadDataOut !== 32'hCAFE0001 || writeRegOut !== 5'd7) begin
      errors++; $display("FAIL b2b_wb1: got %b %h %0d want 1 cafe0001 7", RegWriteOut, ReadDataOut, writeRegOut);
    end
    ALUresult = 32'h104; writeReg = 5'd8; dmem_bus.dmem_rdata = 32'h000055AA;
    #1;
    checks++; if (stall !== 1'b0 || dmem_bus.dmem_req !== 1'b1) begin errors++; $display("FAIL b2b_second: got stall=%b req=%b want 0 1", stall, dmem_bus.dmem_req); end
    tick();
    checks++; if (ReadDataOut !== 32'h000055AA || ALUResultOut !== 32'h104 || writeRegOut !== 5'd8) begin
      errors++; $display("FAIL b2b_wb2: got %h %h %0d want 55aa 104 8", ReadDataOut, ALUResultOut, writeRegOut);
    end
    idle_inputs();
    RegWrite = 1; ALUresult = 32'h77; writeReg = 5'd9;
    tick();
    checks++; if (RegWriteOut !== 1'b1 || MemtoRegOut !== 1'b0 || ReadDataOut !== 32'h0 || ALUResultOut !== 32'h77) begin
      errors++; $display("FAIL b2b_alu: got %b %b %h %h want 1 0 0 77", RegWriteOut, MemtoRegOut, ReadDataOut, ALUResultOut);
    end
    idle_inputs();
  endtask

  task automatic test_branch;
    inBranchTaken = 1; inBranchTarget = 8'h2A;
    #1;
    checks++; if (pc_redirect !== 1'b1 || redirect_target !== 8'h2A) begin errors++; $display("FAIL br_plain: got %b %h want 1 2a", pc_redirect, redirect_target); end
    tick();
    MemRead = 1; ALUresult = 32'h50;
    #1;
    checks++; if (pc_redirect !== 1'b0) begin errors++; $display("FAIL br_held_c0: got %b want 0", pc_redirect); end
    tick();
    checks++; if (pc_redirect !== 1'b0) begin errors++; $display("FAIL br_held_c1: got %b want 0", pc_redirect); end
    dmem_bus.dmem_ack = 1;
    #1;
    checks++; if (pc_redirect !== 1'b1 || redirect_target !== 8'h2A) begin errors++; $display("FAIL br_release: got %b %h want 1 2a", pc_redirect, redirect_target); end
    tick();
    idle_inputs();
  endtask

  task automatic test_timeout;
    MemRead = 1; RegWrite = 1; ALUresult = 32'h40; writeReg = 5'd4;
    #1;
    for (int c = 0; c < 4; c++) begin
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL to_stall_c%0d: got %b want 1", c, stall); end
      tick();
    end
    checks++; if (stall !== 1'b0 || dmem_bus.dmem_req !== 1'b1 || bus_error !== 1'b0) begin
      errors++; $display("FAIL to_final: got stall=%b req=%b berr=%b want 0 1 0", stall, dmem_bus.dmem_req, bus_error);
    end
    tick();
    checks++; if (bus_error !== 1'b1 || RegWriteOut !== 1'b0) begin errors++; $display("FAIL to_abort: got berr=%b rw=%b want 1 0", bus_error, RegWriteOut); end
    idle_inputs();
    tick(); tick();
    checks++; if (bus_error !== 1'b1 || dmem_bus.dmem_req !== 1'b0) begin errors++; $display("FAIL to_sticky: got berr=%b req=%b want 1 0", bus_error, dmem_bus.dmem_req); end
  endtask

  task automatic test_reset_mid_wait;
    MemWrite = 1; RegWrite = 1; ALUresult = 32'h60; writedata = 32'hA5A5; writeReg = 5'd6;
    tick(); tick();
    reset = 1'b1;
    #1;
    checks++; if (dmem_bus.dmem_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL rmw_async: got req=%b stall=%b want 0 0", dmem_bus.dmem_req, stall); end
    checks++; if (bus_error !== 1'b0 || RegWriteOut !== 1'b0 || ALUResultOut !== 32'h0) begin
      errors++; $display("FAIL rmw_regs: got berr=%b rw=%b alu=%h want 0 0 0", bus_error, RegWriteOut, ALUResultOut);
    end
    tick();
    reset = 1'b0;
    idle_inputs();
    #1;
    checks++; if (dmem_bus.dmem_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL rmw_idle_after: got req=%b stall=%b want 0 0", dmem_bus.dmem_req, stall); end
    tick();
  endtask

  task automatic test_timeout_ack_boundary;
    MemRead = 1; RegWrite = 1; MemtoReg = 1; ALUresult = 32'h44; writeReg = 5'd10;
    for (int c = 0; c < 4; c++) tick();
    dmem_bus.dmem_ack = 1; dmem_bus.dmem_rdata = 32'h0BADF00D;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL tab_stall: got %b want 0", stall); end
    tick();
    checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL tab_bus_error: got %b want 0", bus_error); end
    checks++; if (RegWriteOut !== 1'b1 || ReadDataOut !== 32'h0BADF00D || writeRegOut !== 5'd10) begin
      errors++; $display("FAIL tab_wb: got %b %h %0d want 1 0badf00d 10", RegWriteOut, ReadDataOut, writeRegOut);
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_zero_wait_load();
    test_store_wait();
    test_misaligned();
    test_back_to_back();
    test_branch();
    test_timeout();
    test_reset_mid_wait();
    test_timeout_ack_boundary();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
